// File: rtl/imem_loader.sv
// imem_loader: streams 32-bit instruction words into a byte-wide instruction
// memory, little-endian, four byte writes per word. The processor core is held
// in reset until the last word of the image has been written.
//
// Ports:
//   i_clk          clock, rising edge
//   i_rst_n        asynchronous active-low reset
//   i_start        restart a load from address 0 (honoured only in DONE)
//   i_in_valid     i_in_word / i_in_last valid
//   o_in_ready     loader can accept a word this cycle
//   i_in_word      instruction word, byte 0 = i_in_word[7:0]
//   i_in_last      final word of the image
//   o_mem_we       byte write strobe
//   o_mem_addr     byte address
//   o_mem_wdata    byte data
//   o_core_hold    1 = hold the processor in reset
//   o_load_done    image loaded
//   o_overflow     sticky: a word was offered with no room left
//   o_checksum     modulo-256 sum of written bytes
//
// Build option: define IMEM_LOADER_CHECKSUM_EN to enable the running checksum;
// otherwise o_checksum is tied to zero.
//
// state | meaning
// IDLE  | waiting for a word, o_in_ready high
// WRITE | emitting the four bytes of the latched word
// DONE  | image loaded (or overflowed), core released, waiting for i_start

module imem_loader #(
  parameter int DEPTH  = 64,
  parameter int ADDR_W = 6
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_start,
  input  logic              i_in_valid,
  output logic              o_in_ready,
  input  logic [31:0]       i_in_word,
  input  logic              i_in_last,
  output logic              o_mem_we,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [7:0]        o_mem_wdata,
  output logic              o_core_hold,
  output logic              o_load_done,
  output logic              o_overflow,
  output logic [7:0]        o_checksum
);

  typedef enum logic [1:0] {IDLE, WRITE, DONE} state_t;

  // One extra pointer bit so a completely filled memory is not mistaken for
  // an empty one.
  localparam logic [ADDR_W:0] DEPTH_W = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] FOUR_W  = (ADDR_W+1)'(4);

  state_t            r_state, w_state_nxt;
  logic [ADDR_W:0]   r_wp, w_wp_nxt;
  logic [1:0]        r_bi, w_bi_nxt;
  logic [31:0]       r_word, w_word_nxt;
  logic              r_last, w_last_nxt;
  logic              r_mem_we, w_mem_we_nxt;
  logic [ADDR_W-1:0] r_mem_addr, w_mem_addr_nxt;
  logic [7:0]        r_mem_wdata, w_mem_wdata_nxt;
  logic              r_core_hold, w_core_hold_nxt;
  logic              r_load_done, w_load_done_nxt;
  logic              r_overflow, w_overflow_nxt;

  logic              w_room;
  logic [1:0]        w_bi_inc;
  logic              w_restart;

  assign w_room    = (r_wp + FOUR_W) <= DEPTH_W;
  assign w_bi_inc  = r_bi + 2'd1;
  assign w_restart = (r_state == DONE) && i_start;

  // Ready is gated by reset so nothing can handshake while reset is held.
  assign o_in_ready = i_rst_n && (r_state == IDLE);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= IDLE;
      r_wp        <= '0;
      r_bi        <= '0;
      r_word      <= '0;
      r_last      <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_core_hold <= 1'b1;
      r_load_done <= 1'b0;
      r_overflow  <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_wp        <= w_wp_nxt;
      r_bi        <= w_bi_nxt;
      r_word      <= w_word_nxt;
      r_last      <= w_last_nxt;
      r_mem_we    <= w_mem_we_nxt;
      r_mem_addr  <= w_mem_addr_nxt;
      r_mem_wdata <= w_mem_wdata_nxt;
      r_core_hold <= w_core_hold_nxt;
      r_load_done <= w_load_done_nxt;
      r_overflow  <= w_overflow_nxt;
    end
  end

  // The memory outputs are registered, so each byte is loaded one edge ahead
  // of the cycle in which it is presented: byte 0 on the accept edge, byte
  // bi+1 while WRITE shows byte bi.
  always_comb begin
    w_state_nxt     = r_state;
    w_wp_nxt        = r_wp;
    w_bi_nxt        = r_bi;
    w_word_nxt      = r_word;
    w_last_nxt      = r_last;
    w_mem_we_nxt    = 1'b0;
    w_mem_addr_nxt  = r_mem_addr;
    w_mem_wdata_nxt = r_mem_wdata;
    w_core_hold_nxt = r_core_hold;
    w_load_done_nxt = r_load_done;
    w_overflow_nxt  = r_overflow;
    case (r_state)
      IDLE: begin
        if (i_in_valid) begin
          if (w_room) begin
            w_state_nxt     = WRITE;
            w_bi_nxt        = 2'd0;
            w_word_nxt      = i_in_word;
            w_last_nxt      = i_in_last;
            w_mem_we_nxt    = 1'b1;
            w_mem_addr_nxt  = r_wp[ADDR_W-1:0];
            w_mem_wdata_nxt = i_in_word[7:0];
          end else begin
            w_state_nxt     = DONE;
            w_overflow_nxt  = 1'b1;
            w_load_done_nxt = 1'b1;
            w_core_hold_nxt = 1'b0;
          end
        end
      end
      WRITE: begin
        if (r_bi == 2'd3) begin
          w_wp_nxt = r_wp + FOUR_W;
          if (r_last) begin
            w_state_nxt     = DONE;
            w_load_done_nxt = 1'b1;
            w_core_hold_nxt = 1'b0;
          end else begin
            w_state_nxt = IDLE;
          end
        end else begin
          w_bi_nxt        = w_bi_inc;
          w_mem_we_nxt    = 1'b1;
          w_mem_addr_nxt  = r_wp[ADDR_W-1:0] + ADDR_W'(w_bi_inc);
          w_mem_wdata_nxt = r_word[{w_bi_inc, 3'b000} +: 8];
        end
      end
      DONE: begin
        if (i_start) begin
          w_state_nxt     = IDLE;
          w_wp_nxt        = '0;
          w_load_done_nxt = 1'b0;
          w_core_hold_nxt = 1'b1;
          w_overflow_nxt  = 1'b0;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign o_mem_we    = r_mem_we;
  assign o_mem_addr  = r_mem_addr;
  assign o_mem_wdata = r_mem_wdata;
  assign o_core_hold = r_core_hold;
  assign o_load_done = r_load_done;
  assign o_overflow  = r_overflow;

`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0] r_checksum;

  // Sums the byte the memory captures on this edge.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_checksum <= '0;
    end else if (w_restart) begin
      r_checksum <= '0;
    end else if (r_mem_we) begin
      r_checksum <= r_checksum + r_mem_wdata;
    end
  end

  assign o_checksum = r_checksum;
`else
  logic w_unused_restart;
  assign w_unused_restart = w_restart;
  assign o_checksum       = 8'h00;
`endif

endmodule

// File: tb/tb_imem_loader.sv
module tb_imem_loader;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  // DEPTH=64 instance
  logic        start, in_valid, in_last;
  logic [31:0] in_word;
  logic        in_ready, mem_we, core_hold, load_done, overflow;
  logic [5:0]  mem_addr;
  logic [7:0]  mem_wdata, checksum;

  // DEPTH=8 instance
  logic        s8_start, s8_in_valid, s8_in_last;
  logic [31:0] s8_in_word;
  logic        s8_in_ready, s8_mem_we, s8_core_hold, s8_load_done, s8_overflow;
  logic [2:0]  s8_mem_addr;
  logic [7:0]  s8_mem_wdata, s8_checksum;

  imem_loader #(.DEPTH(64), .ADDR_W(6)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_in_valid(in_valid),
    .o_in_ready(in_ready), .i_in_word(in_word), .i_in_last(in_last),
    .o_mem_we(mem_we), .o_mem_addr(mem_addr), .o_mem_wdata(mem_wdata),
    .o_core_hold(core_hold), .o_load_done(load_done), .o_overflow(overflow),
    .o_checksum(checksum)
  );

  imem_loader #(.DEPTH(8), .ADDR_W(3)) dut8 (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(s8_start), .i_in_valid(s8_in_valid),
    .o_in_ready(s8_in_ready), .i_in_word(s8_in_word), .i_in_last(s8_in_last),
    .o_mem_we(s8_mem_we), .o_mem_addr(s8_mem_addr), .o_mem_wdata(s8_mem_wdata),
    .o_core_hold(s8_core_hold), .o_load_done(s8_load_done), .o_overflow(s8_overflow),
    .o_checksum(s8_checksum)
  );

  typedef struct {
    int         addr;
    logic [7:0] data;
  } wr_t;

  wr_t q64[$];
  wr_t q8[$];
  int  exp_wp64 = 0;
  int  exp_wp8  = 0;
  logic [7:0] exp_cs64 = 8'h00;
  logic [7:0] exp_cs8  = 8'h00;

  int total = 0;
  int bad   = 0;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endfunction

  function automatic logic [7:0] cs_exp(logic [7:0] model);
`ifdef IMEM_LOADER_CHECKSUM_EN
    return model;
`else
    return 8'h00 & model;
`endif
  endfunction

  // Push the first n bytes of a word as expected writes.
  function automatic void push_bytes(bit d8, logic [31:0] w, int n);
    for (int b = 0; b < n; b++) begin
      wr_t e;
      e.data = w[8*b +: 8];
      if (d8) begin
        e.addr = exp_wp8 + b;
        exp_cs8 = exp_cs8 + e.data;
        q8.push_back(e);
      end else begin
        e.addr = exp_wp64 + b;
        exp_cs64 = exp_cs64 + e.data;
        q64.push_back(e);
      end
    end
    if (n == 4) begin
      if (d8) exp_wp8 += 4;
      else    exp_wp64 += 4;
    end
  endfunction

  // Monitors: every presented byte write must match the head of its queue.
  always @(negedge clk) begin
    if (rst_n && mem_we) begin
      if (q64.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_write64 addr=%0h data=%0h", mem_addr, mem_wdata);
      end else begin
        wr_t e;
        e = q64.pop_front();
        check("wr64_addr", 32'(mem_addr), 32'(e.addr));
        check("wr64_data", 32'(mem_wdata), 32'(e.data));
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && s8_mem_we) begin
      if (q8.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_write8 addr=%0h data=%0h", s8_mem_addr, s8_mem_wdata);
      end else begin
        wr_t e;
        e = q8.pop_front();
        check("wr8_addr", 32'(s8_mem_addr), 32'(e.addr));
        check("wr8_data", 32'(s8_mem_wdata), 32'(e.data));
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Offer one word, wait (bounded) for ready, complete the handshake.
  // Returns the number of cycles spent waiting for ready.
  task automatic send(input bit d8, input logic [31:0] w, input bit last, output int waited);
    waited = 0;
    if (d8) begin
      s8_in_valid = 1'b1; s8_in_word = w; s8_in_last = last;
      while (!s8_in_ready && waited < 50) begin tick(); waited++; end
    end else begin
      in_valid = 1'b1; in_word = w; in_last = last;
      while (!in_ready && waited < 50) begin tick(); waited++; end
    end
    if (waited >= 50) begin
      total++;
      bad++;
      $display("FAIL ready_timeout word=%0h waited=%0d", w, waited);
    end
    tick();
    if (d8) begin
      s8_in_valid = 1'b0; s8_in_word = ~w; s8_in_last = ~last;
    end else begin
      in_valid = 1'b0; in_word = ~w; in_last = ~last;
    end
  endtask

  task automatic pulse_start;
    start = 1'b1;
    tick();
    start = 1'b0;
    exp_wp64 = 0;
    exp_cs64 = 8'h00;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    int wt, wt2;
    start = 0; in_valid = 0; in_last = 0; in_word = 0;
    s8_start = 0; s8_in_valid = 0; s8_in_last = 0; s8_in_word = 0;

    // Reset values while reset is held
    #1 rst_n = 1'b0;
    #2;
    check("rst_in_ready", 32'(in_ready), 0);
    check("rst_mem_we", 32'(mem_we), 0);
    check("rst_mem_addr", 32'(mem_addr), 0);
    check("rst_mem_wdata", 32'(mem_wdata), 0);
    check("rst_core_hold", 32'(core_hold), 1);
    check("rst_load_done", 32'(load_done), 0);
    check("rst_overflow", 32'(overflow), 0);
    check("rst_checksum", 32'(checksum), 0);
    tick();
    rst_n = 1'b1;
    tick();
    check("idle_in_ready", 32'(in_ready), 1);

    // Single word, last
    push_bytes(0, 32'h00500093, 4);
    send(0, 32'h00500093, 1'b1, wt);
    check("t1_not_done_yet", 32'(load_done), 0);
    repeat (4) tick();
    check("t1_load_done", 32'(load_done), 1);
    check("t1_core_hold", 32'(core_hold), 0);
    check("t1_checksum", 32'(checksum), 32'(cs_exp(8'hE3)));

    // in_valid in DONE is ignored
    in_valid = 1'b1; in_word = 32'h12345678; in_last = 1'b1;
    repeat (3) tick();
    check("done_in_ready", 32'(in_ready), 0);
    in_valid = 1'b0;

    // Restart, then back-to-back words
    pulse_start();
    check("start_load_done", 32'(load_done), 0);
    check("start_core_hold", 32'(core_hold), 1);
    check("start_in_ready", 32'(in_ready), 1);
    check("start_checksum", 32'(checksum), 0);
    push_bytes(0, 32'h11223344, 4);
    send(0, 32'h11223344, 1'b0, wt);
    push_bytes(0, 32'hAABBCCDD, 4);
    send(0, 32'hAABBCCDD, 1'b1, wt2);
    check("b2b_ready_low_cycles", 32'(wt2), 4);
    repeat (4) tick();
    check("b2b_load_done", 32'(load_done), 1);
    check("b2b_checksum", 32'(checksum), 32'(cs_exp(exp_cs64)));

    // Restart, DEADBEEF, with a start pulse during WRITE
    pulse_start();
    check("s2_load_done_fell", 32'(load_done), 0);
    push_bytes(0, 32'hDEADBEEF, 4);
    send(0, 32'hDEADBEEF, 1'b1, wt);
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    check("write_start_ignored_done", 32'(load_done), 0);
    repeat (2) tick();
    check("s2_load_done_rose", 32'(load_done), 1);
    check("s2_core_hold", 32'(core_hold), 0);
    check("s2_checksum", 32'(checksum), 32'(cs_exp(exp_cs64)));

    // Reset in the middle of a word, after its 2nd byte write
    pulse_start();
    push_bytes(0, 32'h01020304, 2);
    send(0, 32'h01020304, 1'b0, wt);
    repeat (2) tick();
    rst_n = 1'b0;
    #1;
    check("mid_rst_mem_we", 32'(mem_we), 0);
    check("mid_rst_mem_addr", 32'(mem_addr), 0);
    check("mid_rst_mem_wdata", 32'(mem_wdata), 0);
    check("mid_rst_in_ready", 32'(in_ready), 0);
    check("mid_rst_core_hold", 32'(core_hold), 1);
    check("mid_rst_checksum", 32'(checksum), 0);
    exp_wp64 = 0;
    exp_cs64 = 8'h00;
    tick();
    rst_n = 1'b1;
    tick();
    push_bytes(0, 32'h0A0B0C0D, 4);
    send(0, 32'h0A0B0C0D, 1'b1, wt);
    repeat (4) tick();
    check("post_rst_load_done", 32'(load_done), 1);
    check("post_rst_checksum", 32'(checksum), 32'(cs_exp(exp_cs64)));

    // DEPTH=8: third word overflows and is dropped
    push_bytes(1, 32'h87654321, 4);
    send(1, 32'h87654321, 1'b0, wt);
    push_bytes(1, 32'h0F1E2D3C, 4);
    send(1, 32'h0F1E2D3C, 1'b0, wt);
    send(1, 32'h55AA55AA, 1'b1, wt);
    check("ovf_overflow", 32'(s8_overflow), 1);
    check("ovf_load_done", 32'(s8_load_done), 1);
    check("ovf_core_hold", 32'(s8_core_hold), 0);
    check("ovf_mem_we", 32'(s8_mem_we), 0);
    repeat (3) tick();
    check("ovf_in_ready", 32'(s8_in_ready), 0);
    check("ovf_checksum", 32'(s8_checksum), 32'(cs_exp(exp_cs8)));

    repeat (3) tick();
    check("leftover64", 32'(q64.size()), 0);
    check("leftover8", 32'(q8.size()), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Writer-side counterpart to the fetch stage's byte-wide instruction-memory read path.
- Accepts 32-bit instruction words over a valid/ready stream.
- Writes each word little-endian as 4 consecutive bytes into the byte-wide instruction memory.
- Holds the processor core in reset until the program image is fully loaded.

Parameters:
- DEPTH, 64, instruction memory size in bytes; must be a multiple of 4 and at least 4.
- ADDR_W, 6, byte address width; must satisfy 2**ADDR_W >= DEPTH.

Ports:
- clock  input  1  single clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  single-cycle pulse; restarts a load from address 0; honoured only in DONE.
- in_valid  input  1  in_word/in_last valid.
- in_ready  output  1  loader can accept a word this cycle.
- in_word  input  32  instruction word; byte 0 = in_word[7:0].
- in_last  input  1  marks the final word of the image.
- mem_we  output  1  byte write strobe to instruction memory.
- mem_addr  output  ADDR_W  byte address.
- mem_wdata  output  8  byte data.
- core_hold  output  1  1 = hold the processor in reset.
- load_done  output  1  image loaded; the core may run.
- overflow  output  1  sticky: a word was offered with no room left.
- checksum  output  8  running byte sum (optional feature).

Behaviour:
- States: IDLE, WRITE, DONE.
- Reset (async, reset=0), from any state including mid-WRITE:
  - state goes to IDLE; write pointer wp=0; byte index bi=0.
  - in_ready=0 while reset is asserted, then 1 in IDLE.
  - mem_we=0, mem_addr=0, mem_wdata=0.
  - core_hold=1, load_done=0, overflow=0, checksum=0.
- IDLE:
  - in_ready=1, mem_we=0.
  - A word is accepted on a cycle with in_valid && in_ready.
  - On accept with wp+4 <= DEPTH: latch in_word and in_last, set bi=0, go to WRITE.
  - On accept with wp+4 > DEPTH: drop the word, no write, set overflow=1, go to DONE.
- WRITE:
  - in_ready=0 for 4 cycles.
  - Each cycle: mem_we=1, mem_addr=wp+bi, mem_wdata=word[8*bi+7:8*bi], bi increments.
  - After bi=3: wp+=4 (ADDR_W-bit wrap is unreachable given the DEPTH check).
  - Then go to DONE if the latched last=1, otherwise back to IDLE.
- Timing:
  - Word accepted at edge N; bytes are written on edges N+1..N+4.
  - in_ready returns high in the cycle after edge N+4.
  - Throughput is 1 word per 5 cycles.
- DONE:
  - in_ready=0, mem_we=0.
  - core_hold=0, load_done=1, both registered (change on the edge that enters DONE).
- start:
  - start in DONE: next state IDLE, wp=0, load_done=0, core_hold=1, overflow=0, checksum=0.
  - start in IDLE or WRITE: ignored.
  - in_valid in DONE: ignored; no handshake occurs because in_ready=0.
- Other rules:
  - in_last with no preceding words is legal: one word is written, then DONE.
  - Inputs are sampled only on the accept cycle; in_word may change during WRITE without effect.
- All outputs are registered except in_ready, which is decoded from state.

Optional Feature:
- IMEM_LOADER_CHECKSUM_EN defined:
  - checksum = 8-bit modulo-256 sum of every byte written since reset or start.
  - Updated on the edge of each mem_we byte write.
  - Dropped (overflow) words are not summed.
- Undefined: checksum is constant 0 and no adder is synthesised.

Test Plan:
- Reset then single word 0x00500093 with in_last=1:
  - writes (0,0x93),(1,0x00),(2,0x50),(3,0x00) on 4 consecutive edges.
  - then load_done=1, core_hold=0.
  - checksum=0xE3 with the macro, 0 without.
- Back-to-back words 0x11223344, 0xAABBCCDD (last), in_valid held high:
  - in_ready low for 4 cycles between accepts.
  - addresses 0..7 written with 44,33,22,11,DD,CC,BB,AA.
- DEPTH=8, three words, third with in_last=1:
  - first two written to addresses 0..7.
  - third dropped with no mem_we; overflow=1, load_done=1.
- Assert reset low after the 2nd byte write of a word:
  - mem_we drops immediately; all outputs return to reset values asynchronously.
  - after reset release, the next word writes from address 0.
- In DONE, pulse start, load word 0xDEADBEEF (last):
  - load_done falls the cycle after start.
  - bytes EF,BE,AD,DE written at 0..3; load_done rises again.
  - a start pulse during WRITE has no effect.
